rld: RTL and testbench

Run-length decoder: the stage directly downstream of the `rle` compressor. It reads a compressed stream of (count, value) byte pairs from the shared DPSRAM over port A. It expands the stream back to plaintext bytes and writes them, packed into words, to a second DPSRAM region. It uses the same start/done handshake and port A memory protocol as `rle`, so both blocks share one bench and memory model, and a round-trip compress/decompress check is possible.

---
 rtl/rld.sv | 192 +++++++++++++++++++
 tb/tb_rld.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rld.sv
// Run-length decoder: reads (count, value) byte pairs from memory port A and
// writes the expanded bytes back, packed little-endian into words.
// Optional build macro: RLD_ERROR_EN adds a sticky `error` output.
module rld (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [31:0] rle_addr,
    input  logic [31:0] rle_size,
    input  logic [31:0] message_addr,
    output logic [31:0] message_size,
    output logic        done,
    output logic        port_A_clk,
    output logic [15:0] port_A_addr,
    output logic [31:0] port_A_data_in,
    input  logic [31:0] port_A_data_out,
    output logic        port_A_we
`ifdef RLD_ERROR_EN
    ,
    output logic        error
`endif
);

    typedef enum logic [3:0] {
        StIdle, StRdAddr, StRdWait, StRdLatch, StParse, StExpand, StWr, StFlush, StDone
    } state_e;

    state_e      r_state;
    logic [15:0] r_rd_addr;
    logic [15:0] r_wr_addr;
    logic [31:0] r_left;      // input bytes still to consume (even-truncated)
    logic [31:0] r_buf;
    logic [1:0]  r_idx;
    logic        r_buf_empty;
    logic        r_have_cnt;  // count byte taken, value byte pending
    logic [7:0]  r_count;
    logic [7:0]  r_value;
    logic [31:0] r_acc;
    logic [1:0]  r_acc_idx;
    logic [31:0] r_msize;
    logic        r_done;
    logic        r_we;
    logic [15:0] r_addr;
    logic [31:0] r_data;
`ifdef RLD_ERROR_EN
    logic        r_error;
`endif

    logic [7:0]  w_byte;
    logic [31:0] w_left_dec;
    logic        w_accept;
    state_e      w_after_pair;
    state_e      w_parse_next;
    logic        w_unused;

    assign w_byte     = r_buf[{r_idx, 3'b000} +: 8];
    assign w_left_dec = r_left - 32'd1;
    assign w_accept   = start && (r_state == StIdle || r_state == StDone);
    // Where to go once a run is finished: end, refill, or keep parsing.
    assign w_after_pair = (r_left == 32'd0) ? StFlush : (r_buf_empty ? StRdAddr : StParse);
    // Where to go after consuming a byte that does not start an expansion.
    assign w_parse_next = (w_left_dec == 32'd0) ? StFlush :
                          ((r_idx == 2'd3) ? StRdAddr : StParse);
    assign w_unused = ^{rle_addr[31:16], rle_addr[1:0], message_addr[31:16],
                        message_addr[1:0], rle_size[0]};

    assign port_A_clk     = clk;
    assign port_A_addr    = r_addr;
    assign port_A_data_in = r_data;
    assign port_A_we      = r_we;
    assign message_size   = r_msize;
    assign done           = r_done;
`ifdef RLD_ERROR_EN
    assign error          = r_error;
`endif

    // Decoder FSM with registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state     <= StIdle;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_left      <= '0;
            r_buf       <= '0;
            r_idx       <= '0;
            r_buf_empty <= 1'b1;
            r_have_cnt  <= 1'b0;
            r_count     <= '0;
            r_value     <= '0;
            r_acc       <= '0;
            r_acc_idx   <= '0;
            r_msize     <= '0;
            r_done      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
`ifdef RLD_ERROR_EN
            r_error     <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                r_msize     <= '0;
                r_done      <= 1'b0;
                r_rd_addr   <= {rle_addr[15:2], 2'b00};
                r_wr_addr   <= {message_addr[15:2], 2'b00};
                r_left      <= {rle_size[31:1], 1'b0};
                r_buf_empty <= 1'b1;
                r_have_cnt  <= 1'b0;
                r_idx       <= '0;
                r_acc       <= '0;
                r_acc_idx   <= '0;
                r_count     <= '0;
`ifdef RLD_ERROR_EN
                r_error     <= rle_size[0];
`endif
                r_state     <= (rle_size[31:1] == 31'd0) ? StFlush : StRdAddr;
            end else begin
                case (r_state)
                    StRdAddr: begin
                        r_addr  <= {r_rd_addr[15:2], 2'b00};
                        r_state <= StRdWait;
                    end
                    StRdWait: r_state <= StRdLatch;
                    StRdLatch: begin
                        r_buf       <= port_A_data_out;
                        r_idx       <= '0;
                        r_buf_empty <= 1'b0;
                        r_rd_addr   <= r_rd_addr + 16'd4;
                        r_state     <= StParse;
                    end
                    StParse: begin
                        r_left      <= w_left_dec;
                        r_idx       <= r_idx + 2'd1;
                        r_buf_empty <= (r_idx == 2'd3);
                        if (!r_have_cnt) begin
                            r_count    <= w_byte;
                            r_have_cnt <= 1'b1;
                            r_state    <= w_parse_next;
                        end else begin
                            r_value    <= w_byte;
                            r_have_cnt <= 1'b0;
                            if (r_count != 8'd0) begin
                                r_state <= StExpand;
                            end else begin
`ifdef RLD_ERROR_EN
                                r_error <= 1'b1;
`endif
                                r_state <= w_parse_next;
                            end
                        end
                    end
                    StExpand: begin
                        r_acc[{r_acc_idx, 3'b000} +: 8] <= r_value;
                        r_acc_idx <= r_acc_idx + 2'd1;
                        r_msize   <= r_msize + 32'd1;
                        r_count   <= r_count - 8'd1;
                        if (r_acc_idx == 2'd3) begin
                            r_state <= StWr;
                        end else if (r_count == 8'd1) begin
                            r_state <= w_after_pair;
                        end
                    end
                    StWr: begin
                        r_we      <= 1'b1;
                        r_addr    <= r_wr_addr;
                        r_data    <= r_acc;
                        r_acc     <= '0;
                        r_wr_addr <= r_wr_addr + 16'd4;
                        r_state   <= (r_count != 8'd0) ? StExpand : w_after_pair;
                    end
                    StFlush: begin
                        // Write any partial word first, then finish on the following edge.
                        if (r_acc_idx != 2'd0) begin
                            r_we      <= 1'b1;
                            r_addr    <= r_wr_addr;
                            r_data    <= r_acc;
                            r_acc     <= '0;
                            r_acc_idx <= '0;
                            r_wr_addr <= r_wr_addr + 16'd4;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rld.sv
// Directed self-checking bench for rld with a word-wide port A memory model.
module tb_rld;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] rle_addr = '0;
    logic [31:0] rle_size = '0;
    logic [31:0] message_addr = '0;
    logic [31:0] message_size;
    logic        done;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;
    logic        port_A_we;
`ifdef RLD_ERROR_EN
    logic        error;
`endif

    logic [31:0] mem [0:16383];
    logic [31:0] rd_q = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    rld u_dut (
`ifdef RLD_ERROR_EN
        .error           (error),
`endif
        .clk             (clk),
        .nreset          (nreset),
        .start           (start),
        .rle_addr        (rle_addr),
        .rle_size        (rle_size),
        .message_addr    (message_addr),
        .message_size    (message_size),
        .done            (done),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out),
        .port_A_we       (port_A_we)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write on we, read data registered one edge later.
    always @(posedge port_A_clk) begin
        if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
        rd_q <= mem[port_A_addr[15:2]];
    end
    assign port_A_data_out = rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] a, input logic [31:0] s, input logic [31:0] m);
        @(negedge clk);
        rle_addr = a;
        rle_size = s;
        message_addr = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_msize"}, message_size, 32'd0);
        check({tag, "_we"}, {31'd0, port_A_we}, 32'd0);
        check({tag, "_addr"}, {16'd0, port_A_addr}, 32'd0);
        check({tag, "_wdata"}, port_A_data_in, 32'd0);
    endtask

    initial begin
        logic seen_we;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        nreset = 1'b1;

        // Basic: 2x'A', 3x'B'
        mem[16'hC8 >> 2] = 32'h4203_4102;
        mem[16'h12C >> 2] = 32'hFFFF_FFFF;
        mem[16'h130 >> 2] = 32'hFFFF_FFFF;
        pulse_start(32'hC8, 32'd4, 32'h12C);
        wait_done("t1_done");
        check("t1_w0", mem[16'h12C >> 2], 32'h4242_4141);
        check("t1_w1", mem[16'h130 >> 2], 32'h0000_0042);
        check("t1_msize", message_size, 32'd5);
`ifdef RLD_ERROR_EN
        check("t1_err", {31'd0, error}, 32'd0);
`endif

        // Count-0 pair skipped, odd trailing byte ignored, exact word fill
        mem[16'h300 >> 2] = 32'h9900_1103;
        mem[16'h304 >> 2] = 32'hEE07_2205;
        mem[16'h600 >> 2] = 32'hFFFF_FFFF;
        mem[16'h604 >> 2] = 32'hFFFF_FFFF;
        mem[16'h608 >> 2] = 32'hDEAD_BEEF;
        pulse_start(32'h300, 32'd7, 32'h600);
        wait_done("t2_done");
        check("t2_w0", mem[16'h600 >> 2], 32'h2211_1111);
        check("t2_w1", mem[16'h604 >> 2], 32'h2222_2222);
        check("t2_w2_untouched", mem[16'h608 >> 2], 32'hDEAD_BEEF);
        check("t2_msize", message_size, 32'd8);
`ifdef RLD_ERROR_EN
        check("t2_err", {31'd0, error}, 32'd1);
`endif

        // Two input words, partial final word zero-padded
        mem[16'h340 >> 2] = 32'hBB02_AA01;
        mem[16'h344 >> 2] = 32'h7777_CC03;
        mem[16'h700 >> 2] = 32'hFFFF_FFFF;
        mem[16'h704 >> 2] = 32'hFFFF_FFFF;
        pulse_start(32'h340, 32'd6, 32'h700);
        wait_done("t3_done");
        check("t3_w0", mem[16'h700 >> 2], 32'hCCBB_BBAA);
        check("t3_w1", mem[16'h704 >> 2], 32'h0000_CCCC);
        check("t3_msize", message_size, 32'd6);
`ifdef RLD_ERROR_EN
        check("t3_err", {31'd0, error}, 32'd0);
`endif

        // Empty stream: done after two edges, no write
        seen_we = 1'b0;
        @(negedge clk);
        rle_size = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_we |= port_A_we;
        check("t4_done_low", {31'd0, done}, 32'd0);
        @(negedge clk);
        seen_we |= port_A_we;
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_no_we", {31'd0, seen_we}, 32'd0);
        check("t4_msize", message_size, 32'd0);

        // Reset mid-expansion aborts the decode
        mem[16'h400 >> 2] = 32'h0000_5AFF;
        pulse_start(32'h400, 32'd2, 32'h1000);
        repeat (12) @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        nreset = 1'b1;

        // Decoder recovers after the abort
        mem[16'h12C >> 2] = 32'hFFFF_FFFF;
        mem[16'h130 >> 2] = 32'hFFFF_FFFF;
        pulse_start(32'hC8, 32'd4, 32'h12C);
        wait_done("t5_done");
        check("t5_w0", mem[16'h12C >> 2], 32'h4242_4141);
        check("t5_w1", mem[16'h130 >> 2], 32'h0000_0042);
        check("t5_msize", message_size, 32'd5);

        // Max run of 255, with an ignored start mid-run
        for (int i = 0; i < 65; i++) mem[(16'h1000 >> 2) + i] = 32'hFFFF_FFFF;
        mem[(16'h1000 >> 2) + 64] = 32'hDEAD_BEEF;
        mem[16'h2000 >> 2] = 32'h1234_5678;
        pulse_start(32'h400, 32'd2, 32'h1000);
        repeat (30) @(negedge clk);
        pulse_start(32'hC8, 32'd4, 32'h2000);
        wait_done("t6_done");
        for (int i = 0; i < 63; i++) begin
            check($sformatf("t6_w%0d", i), mem[(16'h1000 >> 2) + i], 32'h5A5A_5A5A);
        end
        check("t6_w63", mem[(16'h1000 >> 2) + 63], 32'h005A_5A5A);
        check("t6_w64_untouched", mem[(16'h1000 >> 2) + 64], 32'hDEAD_BEEF);
        check("t6_busy_start_ignored", mem[16'h2000 >> 2], 32'h1234_5678);
        check("t6_msize", message_size, 32'd255);

`ifdef RLD_ERROR_EN
        // Odd size flags error, decode still completes
        pulse_start(32'hC8, 32'd5, 32'h12C);
        wait_done("t7_done");
        check("t7_err", {31'd0, error}, 32'd1);
        check("t7_msize", message_size, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
